// File: rtl/midi_msg_parser_if.sv
// rtl/midi_msg_parser_if.sv - byte-in / message-out bundle for the MIDI message parser
interface midi_msg_parser_if;
   logic [7:0] byte_in;
   logic       is_status;
   logic       byte_strobe;
   logic       msg_valid;
   logic [3:0] msg_type;
   logic [3:0] msg_channel;
   logic [6:0] msg_d1;
   logic [6:0] msg_d2;
   logic       rt_valid;
   logic [7:0] rt_byte;
   logic [7:0] drop_cnt;

   modport master (
      output byte_in, is_status, byte_strobe,
      input  msg_valid, msg_type, msg_channel, msg_d1, msg_d2,
      input  rt_valid, rt_byte, drop_cnt
   );

   modport slave (
      input  byte_in, is_status, byte_strobe,
      output msg_valid, msg_type, msg_channel, msg_d1, msg_d2,
      output rt_valid, rt_byte, drop_cnt
   );
endinterface

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - groups received MIDI bytes into channel messages with running status
// Optional: MIDI_NOTEON_V0_AS_OFF_EN rewrites note-on with zero velocity as note-off.
module midi_msg_parser #(
   parameter bit         OMNI      = 1'b1,
   parameter logic [3:0] LISTEN_CH = 4'd0
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   midi_msg_parser_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic       r_strobe_d;
   logic [7:0] r_run_status;
   logic [6:0] r_d1;
   logic [7:0] r_drop_cnt;
   logic       r_msg_valid;
   logic [3:0] r_msg_type;
   logic [3:0] r_msg_channel;
   logic [6:0] r_msg_d1;
   logic [6:0] r_msg_d2;
   logic       r_rt_valid;
   logic [7:0] r_rt_byte;

   logic       w_accept;
   logic       w_is_sys;
   logic       w_is_rt;
   logic       w_is_chan;
   logic       w_is_sysex;
   logic       w_is_common;
   logic       w_is_data;
   logic       w_one_data;
   logic       w_ch_ok;

   logic       w_complete;
   logic       w_load_run;
   logic       w_clear_run;
   logic       w_load_d1;
   logic       w_drop;
   logic       w_rt_pulse;
   logic [3:0] w_emit_type;
   logic [6:0] w_emit_d1;
   logic [6:0] w_emit_d2;

   // Only a rising strobe is a new byte; the strobe may stay high for several cycles.
   assign w_accept    = bus.byte_strobe & ~r_strobe_d;
   assign w_is_sys    = bus.is_status & (bus.byte_in[7:4] == 4'hF);
   assign w_is_rt     = bus.is_status & (bus.byte_in[7:3] == 5'h1F);
   assign w_is_chan   = bus.is_status & ~w_is_sys;
   assign w_is_sysex  = w_is_sys & (bus.byte_in[3:0] == 4'h0);
   assign w_is_common = w_is_sys & ~w_is_rt & ~w_is_sysex;
   assign w_is_data   = ~bus.is_status;
   assign w_one_data  = (r_run_status[7:5] == 3'b110);
   assign w_ch_ok     = OMNI || (r_run_status[3:0] == LISTEN_CH);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (w_accept) begin
         if (w_is_rt) begin
            w_next_state = r_state;
         end else if (w_is_chan) begin
            w_next_state = WAIT_D1;
         end else if (w_is_sysex) begin
            w_next_state = SYSEX;
         end else if (w_is_common) begin
            w_next_state = IDLE;
         end else begin
            case (r_state)
               WAIT_D1: if (!w_one_data) w_next_state = WAIT_D2;
               WAIT_D2: w_next_state = WAIT_D1;
               default: w_next_state = r_state;
            endcase
         end
      end
   end

   always_comb begin
      w_complete  = 1'b0;
      w_load_run  = 1'b0;
      w_clear_run = 1'b0;
      w_load_d1   = 1'b0;
      w_drop      = 1'b0;
      w_rt_pulse  = 1'b0;
      w_emit_d1   = r_d1;
      w_emit_d2   = 7'd0;
      if (w_accept) begin
         w_rt_pulse  = w_is_rt;
         w_load_run  = w_is_chan;
         w_clear_run = w_is_sysex | w_is_common;
         if (w_is_data) begin
            case (r_state)
               WAIT_D1: begin
                  w_load_d1 = 1'b1;
                  if (w_one_data) begin
                     w_complete = 1'b1;
                     w_emit_d1  = bus.byte_in[6:0];
                  end
               end
               WAIT_D2: begin
                  w_complete = 1'b1;
                  w_emit_d2  = bus.byte_in[6:0];
               end
               IDLE:    w_drop = 1'b1;
               default: w_drop = 1'b0;
            endcase
         end
      end
`ifdef MIDI_NOTEON_V0_AS_OFF_EN
      w_emit_type = ((r_run_status[7:4] == 4'h9) && (w_emit_d2 == 7'd0)) ? 4'h8
                                                                          : r_run_status[7:4];
`else
      w_emit_type = r_run_status[7:4];
`endif
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_strobe_d    <= 1'b1;
         r_run_status  <= 8'd0;
         r_d1          <= 7'd0;
         r_drop_cnt    <= 8'd0;
         r_msg_valid   <= 1'b0;
         r_msg_type    <= 4'd0;
         r_msg_channel <= 4'd0;
         r_msg_d1      <= 7'd0;
         r_msg_d2      <= 7'd0;
         r_rt_valid    <= 1'b0;
         r_rt_byte     <= 8'd0;
      end else begin
         r_strobe_d <= bus.byte_strobe;
         if (w_load_run) begin
            r_run_status <= bus.byte_in;
         end else if (w_clear_run) begin
            r_run_status <= 8'd0;
         end
         if (w_load_d1) begin
            r_d1 <= bus.byte_in[6:0];
         end
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
         // Filtered channels still advance the state machine but never touch the outputs.
         r_msg_valid <= w_complete & w_ch_ok;
         if (w_complete && w_ch_ok) begin
            r_msg_type    <= w_emit_type;
            r_msg_channel <= r_run_status[3:0];
            r_msg_d1      <= w_emit_d1;
            r_msg_d2      <= w_emit_d2;
         end
         r_rt_valid <= w_rt_pulse;
         if (w_rt_pulse) begin
            r_rt_byte <= bus.byte_in;
         end
      end
   end

   assign bus.msg_valid   = r_msg_valid;
   assign bus.msg_type    = r_msg_type;
   assign bus.msg_channel = r_msg_channel;
   assign bus.msg_d1      = r_msg_d1;
   assign bus.msg_d2      = r_msg_d2;
   assign bus.rt_valid    = r_rt_valid;
   assign bus.rt_byte     = r_rt_byte;
   assign bus.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - directed bench: omni instance and channel-3 filtered instance share one byte stream
module tb_midi_msg_parser;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   midi_msg_parser_if if_a ();
   midi_msg_parser_if if_b ();

   midi_msg_parser #(.OMNI(1'b1), .LISTEN_CH(4'd0)) dut_a (
      .sys_clk (clk),
      .rst_n   (rst_n),
      .bus     (if_a.slave)
   );

   midi_msg_parser #(.OMNI(1'b0), .LISTEN_CH(4'd3)) dut_b (
      .sys_clk (clk),
      .rst_n   (rst_n),
      .bus     (if_b.slave)
   );

   int n_total = 0;
   int n_pass  = 0;

   logic [21:0] qa[$];
   logic [21:0] qb[$];
   logic [7:0]  rtq[$];

   always @(negedge clk) begin
      if (if_a.msg_valid) qa.push_back({if_a.msg_type, if_a.msg_channel, if_a.msg_d1, if_a.msg_d2});
      if (if_b.msg_valid) qb.push_back({if_b.msg_type, if_b.msg_channel, if_b.msg_d1, if_b.msg_d2});
      if (if_a.rt_valid)  rtq.push_back(if_a.rt_byte);
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [21:0] pk(input logic [3:0] t, input logic [3:0] c,
                                       input logic [6:0] d1, input logic [6:0] d2);
      return {t, c, d1, d2};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_byte(input logic [7:0] b);
      if_a.byte_in = b;  if_a.is_status = b[7];  if_a.byte_strobe = 1'b1;
      if_b.byte_in = b;  if_b.is_status = b[7];  if_b.byte_strobe = 1'b1;
   endtask

   task automatic clr_strobe();
      if_a.byte_strobe = 1'b0;
      if_b.byte_strobe = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int hold);
      set_byte(b);
      repeat (hold) @(negedge clk);
      clr_strobe();
      @(negedge clk);
   endtask

   int ma, mb, mr;
   logic [3:0] v0_type;

   initial begin
`ifdef MIDI_NOTEON_V0_AS_OFF_EN
      v0_type = 4'h8;
`else
      v0_type = 4'h9;
`endif
      // Strobe held high through reset release must not count as a byte.
      set_byte(8'h40);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      clr_strobe();
      @(negedge clk);
      chk("rst_msg_valid", if_a.msg_valid, 0);
      chk("rst_msg_type",  if_a.msg_type, 0);
      chk("rst_msg_d1",    if_a.msg_d1, 0);
      chk("rst_rt_byte",   if_a.rt_byte, 0);
      chk("rst_drop_a",    if_a.drop_cnt, 0);
      chk("rst_drop_b",    if_b.drop_cnt, 0);
      chk("rst_no_msgs",   qa.size(), 0);

      // Basic note-on, with exact one-cycle latency on the last byte.
      ma = qa.size(); mb = qb.size(); mr = rtq.size();
      send(8'h92, 1);
      send(8'h3C, 1);
      set_byte(8'h64);
      @(negedge clk);
      chk("lat_pulse", if_a.msg_valid, 1);
      clr_strobe();
      @(negedge clk);
      chk("lat_single", if_a.msg_valid, 0);
      chk("noteon_cnt",  qa.size() - ma, 1);
      chk("noteon_msg",  qa[ma], pk(4'h9, 4'h2, 7'h3C, 7'h64));
      chk("noteon_filt", qb.size() - mb, 0);
      chk("noteon_nort", rtq.size() - mr, 0);

      // Running status, second message with zero velocity.
      ma = qa.size(); mb = qb.size();
      send(8'h90, 1); send(8'h40, 1); send(8'h7F, 1); send(8'h41, 1); send(8'h00, 1);
      chk("run_cnt",  qa.size() - ma, 2);
      chk("run_msg0", qa[ma],   pk(4'h9, 4'h0, 7'h40, 7'h7F));
      chk("run_msg1", qa[ma+1], pk(v0_type, 4'h0, 7'h41, 7'h00));
      chk("run_filt", qb.size() - mb, 0);

      // Real-time byte between data bytes.
      ma = qa.size(); mr = rtq.size();
      send(8'hB1, 1); send(8'h07, 1); send(8'hF8, 1); send(8'h50, 1);
      chk("rt_cnt",   rtq.size() - mr, 1);
      chk("rt_val",   rtq[mr], 8'hF8);
      chk("rt_hold",  if_a.rt_byte, 8'hF8);
      chk("cc_cnt",   qa.size() - ma, 1);
      chk("cc_msg",   qa[ma], pk(4'hB, 4'h1, 7'h07, 7'h50));

      // One-data-byte messages under running status.
      ma = qa.size();
      send(8'hC5, 1); send(8'h0A, 1); send(8'h0B, 1);
      chk("pc_cnt",  qa.size() - ma, 2);
      chk("pc_msg0", qa[ma],   pk(4'hC, 4'h5, 7'h0A, 7'h00));
      chk("pc_msg1", qa[ma+1], pk(4'hC, 4'h5, 7'h0B, 7'h00));
      chk("pc_hold_d1", if_a.msg_d1, 7'h0B);

      // SysEx discards silently; data after EOX with no running status is counted.
      ma = qa.size();
      send(8'hF0, 1); send(8'h7E, 1); send(8'h01, 1); send(8'hF7, 1); send(8'h40, 1);
      chk("sx_cnt",  qa.size() - ma, 0);
      chk("sx_drop", if_a.drop_cnt, 1);

      // Channel filter, then long-held strobes.
      ma = qa.size(); mb = qb.size();
      send(8'h94, 1); send(8'h3C, 1); send(8'h40, 1);
      chk("flt_a_cnt", qa.size() - ma, 1);
      chk("flt_a_msg", qa[ma], pk(4'h9, 4'h4, 7'h3C, 7'h40));
      chk("flt_b_cnt", qb.size() - mb, 0);
      ma = qa.size(); mb = qb.size();
      send(8'h93, 5); send(8'h3C, 5); send(8'h40, 5);
      chk("hold_a_cnt", qa.size() - ma, 1);
      chk("hold_b_cnt", qb.size() - mb, 1);
      chk("hold_b_msg", qb[mb], pk(4'h9, 4'h3, 7'h3C, 7'h40));
      chk("hold_b_ch",  if_b.msg_channel, 4'h3);

      // Reset in the middle of a message.
      ma = qa.size(); mb = qb.size();
      send(8'h93, 1); send(8'h3C, 1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_type", if_a.msg_type, 0);
      rst_n = 1'b1;
      @(negedge clk);
      send(8'h40, 1);
      chk("mid_rst_a_cnt", qa.size() - ma, 0);
      chk("mid_rst_b_cnt", qb.size() - mb, 0);
      chk("mid_rst_drop_a", if_a.drop_cnt, 1);
      chk("mid_rst_drop_b", if_b.drop_cnt, 1);

      // Saturation of the discard counter.
      for (int i = 0; i < 253; i++) send(8'h11, 1);
      chk("drop_254", if_a.drop_cnt, 8'd254);
      send(8'h12, 1);
      chk("drop_255", if_a.drop_cnt, 8'd255);
      send(8'h13, 1); send(8'h14, 1); send(8'h15, 1);
      chk("drop_sat", if_a.drop_cnt, 8'd255);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
